// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR Hamming-distance engine.
package lfsr_pkg;

    // Controller states: waiting for a request, or producing patterns.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Number of set bits in a word of up to 32 bits.
    function automatic logic [5:0] popcount(input logic [31:0] value);
        logic [5:0] total;
        total = '0;
        for (int i = 0; i < 32; i++) begin
            total = total + 6'(value[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step plus the Hamming distance between old and new state.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state,
    output logic [HD_W-1:0]  hd
);

    logic             feedback;
    logic [WIDTH-1:0] tap_mask;
    logic [WIDTH-1:0] diff;

    // Bit 0 of the tap mask has no meaning: the feedback bit always lands there.
    assign tap_mask = taps & {{(WIDTH-1){1'b1}}, 1'b0};
    assign feedback = state[WIDTH-1];

    // Shift left, rotate the MSB into bit 0, and xor it into every tapped position.
    always_comb begin
        next_state = {state[WIDTH-2:0], feedback} ^ (tap_mask & {WIDTH{feedback}});
        diff       = next_state ^ state;
        hd         = HD_W'(popcount(32'(diff)));
    end

endmodule

// File: rtl/lfsr_hd_engine.sv
// Runs a Galois LFSR for a requested number of steps and streams each new
// state together with its Hamming distance from the previous state through
// a valid/ready output slot.
module lfsr_hd_engine
    import lfsr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] taps,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [HD_W-1:0]  out_hd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    fsm_state_t       fsm;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] taps_q;
    logic [CNT_W-1:0] remaining;
    logic             abort_q;

    logic [WIDTH-1:0] step_src;
    logic [WIDTH-1:0] step_taps;
    logic [WIDTH-1:0] step_next;
    logic [HD_W-1:0]  step_hd;
    logic             slot_free;
    logic             abort_pend;

    // In IDLE the stepper works straight from the request inputs, so the first
    // pattern can be loaded on the start edge itself (latency of one cycle).
    assign step_src  = (fsm == IDLE) ? seed : lfsr_state;
    assign step_taps = (fsm == IDLE) ? taps : taps_q;

    lfsr_step #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_step (
        .state      (step_src),
        .taps       (step_taps),
        .next_state (step_next),
        .hd         (step_hd)
    );

    // The output slot can take a new pattern when empty or being drained now.
    assign slot_free  = !out_valid || out_ready;
    assign abort_pend = abort_q || abort;
    assign busy       = (fsm == RUN);

    // Controller, LFSR state and registered output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= IDLE;
            lfsr_state <= '0;
            taps_q     <= '0;
            remaining  <= '0;
            abort_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_hd     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        taps_q     <= taps;
                        lfsr_state <= seed;
                        if (seed == '0) begin
                            // An all-zero seed locks the LFSR: refuse the run.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (num_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            fsm        <= RUN;
                            lfsr_state <= step_next;
                            out_data   <= step_next;
                            out_hd     <= step_hd;
                            out_valid  <= 1'b1;
                            remaining  <= num_steps - CNT_W'(1);
                            abort_q    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort_pend && slot_free) begin
                        // Abort takes effect only once the pattern on display is taken.
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        abort_q   <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else if (slot_free && remaining == '0) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (slot_free) begin
                            lfsr_state <= step_next;
                            out_data   <= step_next;
                            out_hd     <= step_hd;
                            out_valid  <= 1'b1;
                            remaining  <= remaining - CNT_W'(1);
                        end
                        if (abort) begin
                            abort_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_hd_engine.sv
// Self-checking bench for lfsr_hd_engine (WIDTH=8) against a plain arithmetic model.
module tb_lfsr_hd_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  taps;
    logic [7:0]  seed;
    logic [15:0] num_steps;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_hd;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    lfsr_hd_engine #(
        .WIDTH (8),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .taps      (taps),
        .seed      (seed),
        .num_steps (num_steps),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hd    (out_hd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Next LFSR value: double the state modulo 256; if the top bit fell off,
    // fold it back into bit 0 and flip every tapped bit above bit 0.
    function automatic logic [7:0] model_step(input logic [7:0] s, input logic [7:0] tp);
        int v;
        v = (int'(s) * 2) % 256;
        if (int'(s) >= 128) v = v ^ int'(tp & 8'hFE) ^ 1;
        return 8'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one run and follow it to completion, checking every cycle.
    task automatic do_run(input logic [7:0] tp, input logic [7:0] sd, input int n,
                          input int rdy_pct, input int stall_first, input int start_noise);
        logic [7:0] s;
        logic [7:0] exp_d;
        int got;
        int cyc;
        taps      = tp;
        seed      = sd;
        num_steps = 16'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (sd == 8'h00 || n == 0) begin
            check("early_valid", 64'(out_valid), 64'(0));
            check("early_busy",  64'(busy),      64'(0));
            check("early_done",  64'(done),      64'(1));
            check("early_err",   64'(err),       64'(sd == 8'h00));
            tick();
            check("early_done_clr", 64'(done), 64'(0));
            return;
        end
        s   = sd;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 4000) begin
            exp_d = model_step(s, tp);
            check("run_valid", 64'(out_valid), 64'(1));
            check("run_busy",  64'(busy),      64'(1));
            check("run_done",  64'(done),      64'(0));
            check("run_data",  64'(out_data),  64'(exp_d));
            check("run_hd",    64'(out_hd),    64'($countones(exp_d ^ s)));
            out_ready = ($urandom_range(99) < rdy_pct);
            if (stall_first != 0 && got == 0 && cyc < 3) out_ready = 1'b0;
            if (start_noise != 0 && $urandom_range(9) == 0) begin
                start = 1'b1;
                seed  = 8'($urandom);
                taps  = 8'($urandom);
            end
            if (out_ready) begin
                s = exp_d;
                got++;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check("run_count", 64'(got),       64'(n));
        check("end_valid", 64'(out_valid), 64'(0));
        check("end_busy",  64'(busy),      64'(0));
        check("end_done",  64'(done),      64'(1));
        check("end_err",   64'(err),       64'(0));
        out_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] tp;
        logic [7:0] sd;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        taps      = 8'h00;
        seed      = 8'h00;
        num_steps = 16'd0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data",  64'(out_data),  64'(0));
        check("rst_hd",    64'(out_hd),    64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_err",   64'(err),       64'(0));
        reset = 1'b0;
        tick();

        // Single step from 0x80: feedback flips taps and bit 0.
        do_run(8'h1C, 8'h80, 1, 100, 0, 0);
        check("ex1_data_const", 64'(model_step(8'h80, 8'h1C)), 64'(8'h1D));
        // Plain shifting with no feedback: 02, 04, 08.
        do_run(8'h1C, 8'h01, 3, 100, 0, 0);
        // Zero seed is refused with an error; zero steps ends cleanly.
        do_run(8'h1C, 8'h00, 5, 100, 0, 0);
        do_run(8'h1C, 8'h5A, 0, 100, 0, 0);
        // Three stall cycles after the first pattern.
        do_run(8'h1C, 8'h80, 4, 100, 1, 0);

        // Abort raised during a stall ends the run only after that handshake.
        taps = 8'h1C; seed = 8'h01; num_steps = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_first", 64'(out_data), 64'(8'h02));
        tick();
        check("ab_second", 64'(out_data), 64'(8'h04));
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_hold_valid", 64'(out_valid), 64'(1));
        check("ab_hold_data",  64'(out_data),  64'(8'h04));
        check("ab_hold_done",  64'(done),      64'(0));
        tick();
        check("ab_hold2_data", 64'(out_data),  64'(8'h04));
        check("ab_hold2_done", 64'(done),      64'(0));
        out_ready = 1'b1;
        tick();
        check("ab_done",  64'(done),      64'(1));
        check("ab_err",   64'(err),       64'(1));
        check("ab_valid", 64'(out_valid), 64'(0));
        check("ab_busy",  64'(busy),      64'(0));
        tick();
        check("ab_done_clr", 64'(done), 64'(0));

        // Reset in the middle of a stalled run.
        taps = 8'h1C; seed = 8'h37; num_steps = 16'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_valid", 64'(out_valid), 64'(0));
        check("mr_data",  64'(out_data),  64'(0));
        check("mr_hd",    64'(out_hd),    64'(0));
        check("mr_busy",  64'(busy),      64'(0));
        check("mr_done",  64'(done),      64'(0));
        check("mr_err",   64'(err),       64'(0));
        out_ready = 1'b1;
        do_run(8'h1C, 8'h80, 1, 100, 0, 0);

        // Randomised runs with back-pressure and ignored start requests.
        for (int k = 0; k < 8; k++) begin
            tp = 8'($urandom);
            sd = 8'($urandom);
            if (sd == 8'h00) sd = 8'h01;
            do_run(tp, sd, int'($urandom_range(12, 1)), 60, 0, 1);
        end
        // Longer than the period: the sequence simply repeats.
        do_run(8'h8E, 8'hA5, 300, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_hd_engine.md
LFSR_HD_ENGINE -- requirements
Module: lfsr_hd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8; LFSR width, legal 4..32.
REQ-002 SHALL have parameter CNT_W, default 16; step-counter width.
REQ-003 SHALL have derived localparam HD_W = $clog2(WIDTH+1).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-007 taps  in  WIDTH  Galois tap mask; bit 0 ignored.
REQ-008 seed  in  WIDTH  initial LFSR state.
REQ-009 num_steps  in  CNT_W  number of output patterns for the run.
REQ-010 abort  in  1  ends the run at the next accepted handshake.
REQ-011 out_valid  out  1  out_data/out_hd hold a valid pattern.
REQ-012 out_ready  in  1  consumer accepts the pattern when out_valid && out_ready.
REQ-013 out_data  out  WIDTH  generated LFSR state.
REQ-014 out_hd  out  HD_W  Hamming distance between out_data and the preceding state.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  one-cycle pulse at run end.
REQ-017 err  out  1  valid with done; 1 = zero seed or abort.

Function
REQ-018 FSM SHALL have exactly the states IDLE and RUN.
REQ-019 IDLE with start=1: latch taps, seed and num_steps; initialise prev_state to seed.
REQ-020 On start, seed==0: stay IDLE; pulse done=1, err=1 next cycle; no output.
REQ-021 On start, num_steps==0 with nonzero seed: stay IDLE; pulse done=1, err=0 next cycle; no output.
REQ-022 Otherwise the FSM SHALL enter RUN with remaining=num_steps.
REQ-023 Step function, with m = state[WIDTH-1]: next[0]=m; next[i]=state[i-1] ^ (taps[i] & m) for i=1..WIDTH-1.
REQ-024 In RUN with the output slot empty or being accepted this cycle: compute next, load out_data=next and out_hd=popcount(next ^ state), set out_valid=1, state<=next, remaining-=1.
REQ-025 First pattern SHALL be valid the cycle after the start cycle (latency 1 from start).
REQ-026 While out_valid && !out_ready: out_data, out_hd and the internal state SHALL hold stable.
REQ-027 Sustained out_ready=1 SHALL give one pattern per cycle.
REQ-028 After the handshake of the final pattern (remaining==0): out_valid<=0, done=1, err=0, return to IDLE.
REQ-029 abort in RUN SHALL be latched; at the next accepted handshake (or immediately if out_valid=0), clear out_valid, pulse done=1 with err=1, return to IDLE.
REQ-030 start during RUN SHALL be ignored.
REQ-031 remaining SHALL never wrap below zero.
REQ-032 A num_steps above the LFSR period SHALL simply repeat the sequence.

Reset
REQ-033 reset SHALL force IDLE, state=0, remaining=0, out_valid=0, out_data=0, out_hd=0, busy=0, done=0, err=0, and clear the abort latch.
REQ-034 reset SHALL take priority over every other input, including mid-run and mid-stall.

Structure
REQ-035 Package lfsr_pkg SHALL hold the FSM state enum (IDLE, RUN) and a popcount function.
REQ-036 One sub-module, lfsr_step (combinational next state plus HD), SHALL be instantiated once.

Verification
REQ-037 WIDTH=8, taps=8'h1C, seed=8'h80, num_steps=1, out_ready=1 -> out_data=8'h1D, out_hd=5, then done=1, err=0.
REQ-038 seed=8'h01, taps=8'h1C, num_steps=3, ready=1 -> outputs 8'h02, 8'h04, 8'h08 on consecutive cycles; each hd=2.
REQ-039 seed=0, start -> done=1, err=1, out_valid never asserted.
REQ-040 num_steps=4 with out_ready low for 3 cycles after the first valid -> out_data held constant; 4 patterns total; done on the 4th handshake.
REQ-041 abort asserted during a stall -> done with err=1 only after that pattern's handshake.
REQ-042 reset asserted mid-run -> all outputs 0 next cycle; a new start runs correctly.
